// File: rtl/cmp_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : cmp_stream_unit
// Brief    : Streaming comparator with single-beat compares/min/max and
//            running min/max bursts, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module cmp_stream_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         ALU_FUN,
    input  logic               SIGNED,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               IN_LAST,
    output logic [WIDTH-1:0]   CMP_OUT,
    output logic               CMP_Flag,
    output logic [COUNT_W-1:0] CNT,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic [2:0] c_FUN_EQ   = 3'b000;
    localparam logic [2:0] c_FUN_GT   = 3'b001;
    localparam logic [2:0] c_FUN_LT   = 3'b010;
    localparam logic [2:0] c_FUN_NE   = 3'b011;
    localparam logic [2:0] c_FUN_MIN  = 3'b100;
    localparam logic [2:0] c_FUN_MAX  = 3'b101;
    localparam logic [2:0] c_FUN_RMIN = 3'b110;
    localparam logic [2:0] c_FUN_RMAX = 3'b111;

    localparam logic [COUNT_W-1:0] c_CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_CNT_MAX = {COUNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_fun;
    logic               r_sgn;
    logic [WIDTH-1:0]   r_acc;
    logic [COUNT_W-1:0] r_bcnt;
    logic               r_tie;
    logic [WIDTH-1:0]   r_out;
    logic               r_flag;
    logic [COUNT_W-1:0] r_cnt;
    logic               r_valid;

    logic               w_accept;
    logic [2:0]         w_fun;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_rhs;
    logic               w_eq;
    logic               w_gt;
    logic               w_lt;
    logic               w_better;
    logic [2:0]         w_fun_nxt;
    logic               w_sgn_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [COUNT_W-1:0] w_bcnt_nxt;
    logic               w_tie_nxt;
    logic               w_res_load;
    logic [WIDTH-1:0]   w_res_out;
    logic               w_res_flag;
    logic [COUNT_W-1:0] w_res_cnt;

    assign IN_READY  = !RST && (!r_valid || OUT_READY);
    assign w_accept  = IN_VALID && IN_READY;
    assign CMP_OUT   = r_out;
    assign CMP_Flag  = r_flag;
    assign CNT       = r_cnt;
    assign OUT_VALID = r_valid;

    // One comparator serves both modes: against B normally, against the
    // accumulator (with latched opcode/signedness) while a burst is open.
    assign w_fun = (r_state == S_ACC) ? r_fun : ALU_FUN;
    assign w_sgn = (r_state == S_ACC) ? r_sgn : SIGNED;
    assign w_rhs = (r_state == S_ACC) ? r_acc : B;
    assign w_eq  = (A == w_rhs);
    assign w_gt  = w_sgn ? ($signed(A) > $signed(w_rhs)) : (A > w_rhs);
    assign w_lt  = !w_eq && !w_gt;

    always_comb begin
        w_state_nxt = r_state;
        w_fun_nxt   = r_fun;
        w_sgn_nxt   = r_sgn;
        w_acc_nxt   = r_acc;
        w_bcnt_nxt  = r_bcnt;
        w_tie_nxt   = r_tie;
        w_res_load  = 1'b0;
        w_res_out   = '0;
        w_res_flag  = 1'b0;
        w_res_cnt   = c_CNT_ONE;
        w_better    = (w_fun == c_FUN_RMAX) ? w_gt : w_lt;
        if (w_accept) begin
            case (w_fun)
                c_FUN_EQ: begin
                    w_res_load = 1'b1;
                    w_res_flag = w_eq;
                    w_res_out  = WIDTH'(w_eq);
                end
                c_FUN_GT: begin
                    w_res_load = 1'b1;
                    w_res_flag = w_gt;
                    w_res_out  = WIDTH'(w_gt);
                end
                c_FUN_LT: begin
                    w_res_load = 1'b1;
                    w_res_flag = w_lt;
                    w_res_out  = WIDTH'(w_lt);
                end
                c_FUN_NE: begin
                    w_res_load = 1'b1;
                    w_res_flag = !w_eq;
                    w_res_out  = WIDTH'(!w_eq);
                end
                c_FUN_MIN: begin
                    w_res_load = 1'b1;
                    w_res_flag = !w_gt;
                    w_res_out  = w_gt ? B : A;
                end
                c_FUN_MAX: begin
                    w_res_load = 1'b1;
                    w_res_flag = !w_lt;
                    w_res_out  = w_lt ? B : A;
                end
                c_FUN_RMIN, c_FUN_RMAX: begin
                    if (r_state == S_IDLE) begin
                        w_fun_nxt  = ALU_FUN;
                        w_sgn_nxt  = SIGNED;
                        w_acc_nxt  = A;
                        w_bcnt_nxt = c_CNT_ONE;
                        w_tie_nxt  = 1'b0;
                    end else begin
                        // A strictly better value restarts the repeat tracking.
                        w_acc_nxt  = w_better ? A : r_acc;
                        w_tie_nxt  = w_better ? 1'b0 : (r_tie | w_eq);
                        w_bcnt_nxt = (r_bcnt == c_CNT_MAX) ? r_bcnt : r_bcnt + c_CNT_ONE;
                    end
                    if (IN_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_res_load  = 1'b1;
                        w_res_out   = w_acc_nxt;
                        w_res_flag  = w_tie_nxt;
                        w_res_cnt   = w_bcnt_nxt;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_fun   <= 3'b000;
            r_sgn   <= 1'b0;
            r_acc   <= '0;
            r_bcnt  <= '0;
            r_tie   <= 1'b0;
            r_out   <= '0;
            r_flag  <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fun   <= w_fun_nxt;
            r_sgn   <= w_sgn_nxt;
            r_acc   <= w_acc_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_tie   <= w_tie_nxt;
            if (w_res_load) begin
                r_out   <= w_res_out;
                r_flag  <= w_res_flag;
                r_cnt   <= w_res_cnt;
                r_valid <= 1'b1;
            end else if (OUT_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_stream_unit
// Brief    : Scoreboard bench for cmp_stream_unit (COUNT_W=8 and COUNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_cmp_stream_unit;
    logic       CLK;
    logic       RST;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] ALU_FUN;
    logic       SIGNED;
    logic       IN_VALID;
    logic       IN_LAST;
    logic       OUT_READY;
    logic       IN_READY,  IN_READY2;
    logic [7:0] CMP_OUT,   CMP_OUT2;
    logic       CMP_Flag,  CMP_Flag2;
    logic [7:0] CNT;
    logic [1:0] CNT2;
    logic       OUT_VALID, OUT_VALID2;

    cmp_stream_unit #(.WIDTH(8), .COUNT_W(8)) u_dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED(SIGNED),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag), .CNT(CNT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    cmp_stream_unit #(.WIDTH(8), .COUNT_W(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED(SIGNED),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY2), .IN_LAST(IN_LAST),
        .CMP_OUT(CMP_OUT2), .CMP_Flag(CMP_Flag2), .CNT(CNT2),
        .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY)
    );

    typedef struct packed {
        logic [7:0]  out;
        logic        flag;
        logic [31:0] n;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errs   = 0;
    logic       m_ov = 0, m_run = 0, m_tie = 0, m_sg = 0;
    logic [2:0] m_fun = 0;
    logic [7:0] m_acc = 0;
    int         m_n = 0;
    logic       was_rst = 0, stall_prev = 0, took = 0;
    logic [7:0] h_out;
    logic       h_flag;
    logic [7:0] h_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sv(input logic [7:0] x, input logic s);
        return s ? int'($signed(x)) : int'(x);
    endfunction

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model and scoreboard, evaluated mid-cycle for the coming edge.
    always @(negedge CLK) begin
        logic       exp_rdy, res, sg, better;
        logic [2:0] fn;
        int         va, vb, vr;
        exp_t       e;
        exp_rdy = !RST && (!m_ov || OUT_READY);
        chk("out_valid", OUT_VALID, m_ov);
        chk("out_valid2", OUT_VALID2, m_ov);
        chk("in_ready", IN_READY, exp_rdy);
        chk("in_ready2", IN_READY2, exp_rdy);
        if (was_rst) begin
            chk("rst_out", CMP_OUT, 0);
            chk("rst_flag", CMP_Flag, 0);
            chk("rst_cnt", CNT, 0);
            chk("rst_out2", CMP_OUT2, 0);
            chk("rst_cnt2", CNT2, 0);
        end
        if (stall_prev) begin
            chk("hold_out", CMP_OUT, h_out);
            chk("hold_flag", CMP_Flag, h_flag);
            chk("hold_cnt", CNT, h_cnt);
        end
        if (m_ov && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("cmp_out", CMP_OUT, e.out);
                chk("cmp_flag", CMP_Flag, e.flag);
                chk("cnt", CNT, sat(e.n, 255));
                chk("cmp_out2", CMP_OUT2, e.out);
                chk("cmp_flag2", CMP_Flag2, e.flag);
                chk("cnt2", CNT2, sat(e.n, 3));
            end
        end
        stall_prev = !RST && m_ov && !OUT_READY;
        h_out  = CMP_OUT;
        h_flag = CMP_Flag;
        h_cnt  = CNT;
        took = 1'b0;
        res  = 1'b0;
        if (RST) begin
            m_run = 0; m_ov = 0; m_acc = 0; m_n = 0; m_tie = 0;
            sb.delete();
            was_rst = 1'b1;
        end else begin
            was_rst = 1'b0;
            if (IN_VALID && exp_rdy) begin
                took = 1'b1;
                fn = m_run ? m_fun : ALU_FUN;
                sg = m_run ? m_sg : SIGNED;
                va = sv(A, sg);
                vb = sv(B, sg);
                e.n = 1;
                res = 1'b1;
                case (fn)
                    3'd0: begin e.flag = (va == vb); e.out = {7'd0, e.flag}; end
                    3'd1: begin e.flag = (va >  vb); e.out = {7'd0, e.flag}; end
                    3'd2: begin e.flag = (va <  vb); e.out = {7'd0, e.flag}; end
                    3'd3: begin e.flag = (va != vb); e.out = {7'd0, e.flag}; end
                    3'd4: begin e.flag = (va <= vb); e.out = e.flag ? A : B; end
                    3'd5: begin e.flag = (va >= vb); e.out = e.flag ? A : B; end
                    default: begin
                        res = 1'b0;
                        if (!m_run) begin
                            m_fun = fn; m_sg = sg; m_acc = A; m_n = 1; m_tie = 0;
                        end else begin
                            vr = sv(m_acc, m_sg);
                            better = (m_fun == 3'd7) ? (va > vr) : (va < vr);
                            if (better) begin m_acc = A; m_tie = 0; end
                            else if (va == vr) m_tie = 1;
                            m_n++;
                        end
                        if (IN_LAST) begin
                            m_run = 0; res = 1'b1;
                            e.out = m_acc; e.flag = m_tie; e.n = m_n;
                        end else begin
                            m_run = 1;
                        end
                    end
                endcase
                if (res) sb.push_back(e);
            end
            if (res) m_ov = 1'b1;
            else if (OUT_READY) m_ov = 1'b0;
        end
    end

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                        input logic s, input logic l);
        bit ok = 0;
        A = a; B = b; ALU_FUN = f; SIGNED = s; IN_LAST = l; IN_VALID = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1;
            if (took) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        IN_VALID = 1'b0;
    endtask

    initial begin
        bit rdone;
        RST = 1; A = 0; B = 0; ALU_FUN = 0; SIGNED = 0; IN_VALID = 0; IN_LAST = 0;
        OUT_READY = 1;
        repeat (3) @(posedge CLK);
        #1 RST = 0;

        beat(8'd5,   8'd5,   3'd0, 0, 0);
        beat(8'hFF,  8'h01,  3'd1, 1, 0);
        beat(8'hFF,  8'h01,  3'd1, 0, 0);
        beat(8'h03,  8'h04,  3'd2, 0, 0);
        beat(8'h80,  8'h01,  3'd2, 1, 0);
        beat(8'h12,  8'h12,  3'd3, 1, 0);
        beat(8'h42,  8'h42,  3'd4, 0, 0);
        beat(8'hF0,  8'h10,  3'd4, 1, 0);
        beat(8'hF0,  8'h10,  3'd5, 0, 0);
        repeat (2) @(posedge CLK);
        #1;

        // Output stall: result must hold, next beat waits for OUT_READY.
        OUT_READY = 0;
        beat(8'h80, 8'h7F, 3'd5, 1, 0);
        fork
            beat(8'h01, 8'h02, 3'd0, 0, 0);
            begin repeat (4) @(posedge CLK); #1 OUT_READY = 1; end
        join

        beat(8'd3, 8'd0, 3'd7, 0, 0);
        beat(8'd9, 8'd0, 3'd0, 1, 0);
        beat(8'd9, 8'd0, 3'd0, 0, 0);
        beat(8'd2, 8'd0, 3'd1, 0, 1);

        beat(8'd7, 8'd0, 3'd6, 0, 0);
        beat(8'd4, 8'd0, 3'd6, 0, 0);
        RST = 1;
        @(posedge CLK); #1 RST = 0;
        beat(8'd6, 8'd0, 3'd6, 0, 1);

        beat(8'd4, 8'd0, 3'd6, 0, 0);
        beat(8'd4, 8'd0, 3'd6, 0, 0);
        beat(8'd1, 8'd0, 3'd6, 0, 0);
        beat(8'd2, 8'd0, 3'd6, 0, 0);
        beat(8'd3, 8'd0, 3'd6, 0, 1);

        rdone = 0;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    beat(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                         3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
                beat(8'h55, 8'h00, 3'd7, 0, 1);
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge CLK); #1 OUT_READY = 1'($urandom);
                end
                OUT_READY = 1;
            end
        join

        repeat (5) @(posedge CLK);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_stream_unit.md
CMP_STREAM_UNIT -- requirements
Module: cmp_stream_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width, minimum 2.
REQ-002 Parameter COUNT_W, default 8: width of the burst beat counter, minimum 2.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 A, B  input  WIDTH each  operands.
REQ-006 ALU_FUN  input  3  operation code (REQ-011).
REQ-007 SIGNED  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-008 IN_VALID / IN_READY  input 1 / output 1  input handshake; a beat transfers when both are 1.
REQ-009 IN_LAST  input  1  final beat of a running-mode burst; ignored in single-beat modes.
REQ-010 CMP_OUT  output WIDTH, CMP_Flag  output 1, CNT  output COUNT_W, OUT_VALID  output 1, OUT_READY  input 1  result bus and output handshake.

Function
REQ-011 Codes: 000 EQ, 001 GT (A>B), 010 LT (A<B), 011 NE, 100 MIN(A,B), 101 MAX(A,B), 110 RUN_MIN, 111 RUN_MAX.
REQ-012 EQ/GT/LT/NE: CMP_OUT = zero-extended 1-bit result; CMP_Flag = result; CNT = 1.
REQ-013 MIN/MAX: CMP_OUT = selected operand; CMP_Flag = 1 when A is selected; on a tie A is selected and CMP_Flag = 1; CNT = 1.
REQ-014 SIGNED selects the compare for every code; it has no effect on EQ or NE.
REQ-015 Single-beat modes: result registered, OUT_VALID = 1 on the cycle after the accepted beat (latency 1).
REQ-016 RUN_MIN/RUN_MAX operate on A only; B is ignored.
REQ-017 RUN modes use two states, IDLE and ACC; IDLE -> ACC on an accepted RUN beat with IN_LAST = 0; ACC -> IDLE on the accepted beat with IN_LAST = 1.
REQ-018 ALU_FUN and SIGNED are latched on the first beat of a burst; while in ACC, both are ignored and the latched values are used.
REQ-019 Accumulator loads A on the first beat and updates to the running extreme on each later beat.
REQ-020 Intermediate burst beats produce no OUT_VALID.
REQ-021 On the IN_LAST beat, the output register captures CMP_OUT = final extreme, CNT = beat count, and CMP_Flag = 1 if the extreme value was accepted on two or more beats.
REQ-022 CNT saturates at 2^COUNT_W - 1 and does not wrap.
REQ-023 A RUN beat in IDLE with IN_LAST = 1 is a one-beat burst: CMP_OUT = A, CNT = 1, CMP_Flag = 0.
REQ-024 IN_READY = !OUT_VALID || OUT_READY, forced to 0 while RST = 1.
REQ-025 A new beat and an output handoff may both occur in the same cycle with no bubble, giving full throughput.
REQ-026 While OUT_VALID = 1 and OUT_READY = 0, CMP_OUT, CMP_Flag and CNT hold stable.
REQ-027 OUT_VALID clears on a handoff with no new result arriving in the same cycle.
REQ-028 Intermediate RUN beats are also gated by IN_READY.

Reset
REQ-029 While RST = 1 at a rising edge: CMP_OUT = 0, CMP_Flag = 0, CNT = 0, OUT_VALID = 0, accumulator = 0, tie/count state = 0, state = IDLE.
REQ-030 RST takes priority over any handshake in the same cycle.
REQ-031 Reset mid-burst discards the partial burst and produces no output for it.
REQ-032 The first beat after RST deasserts starts a fresh operation.

Verification (WIDTH=8, COUNT_W=8 unless stated)
REQ-033 EQ, A=5, B=5, OUT_READY=1 -> next cycle OUT_VALID=1, CMP_OUT=1, CMP_Flag=1, CNT=1.
REQ-034 GT, A=8'hFF, B=8'h01: SIGNED=1 -> CMP_OUT=0, CMP_Flag=0; SIGNED=0 -> CMP_OUT=1, CMP_Flag=1.
REQ-035 MAX, A=8'h80, B=8'h7F, SIGNED=1, OUT_READY=0, then a second beat offered -> CMP_OUT=8'h7F, CMP_Flag=0 held stable; IN_READY=0; second beat accepted only in the cycle OUT_READY=1.
REQ-036 RUN_MAX burst A=3,9,9,2 with IN_LAST on beat 4 (ALU_FUN changed to EQ on beat 2) -> no OUT_VALID during beats 1-3; single result CMP_OUT=9, CMP_Flag=1, CNT=4.
REQ-037 RUN_MIN, two beats A=7,4, then RST=1 for one cycle, then a one-beat burst A=6 with IN_LAST=1 -> outputs zero during reset; single result CMP_OUT=6, CNT=1, CMP_Flag=0.
REQ-038 COUNT_W=2, RUN_MIN burst of 5 beats A=4,4,1,2,3 -> CMP_OUT=1, CMP_Flag=0, CNT=3 (saturated).
